rvfi_retire_buffer: RTL and testbench



---
 rtl/rvfi_retire_buffer.sv | 177 +++++++++++++++++
 tb/tb_rvfi_retire_buffer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_retire_buffer.sv
// rvfi_retire_buffer: circular FIFO capturing RVFI retirement records for a
// slower trace consumer. It flags dropped records (overflow, drop_count) and
// gaps in rvfi_order (order_err).
// Optional feature macro: RVFI_BUF_MEM_EN stores mem_addr/rmask/wmask per
// entry. When it is undefined, out_mem_* are tied to zero.
module rvfi_retire_buffer #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              rvfi_valid,
  input  logic [63:0]       rvfi_order,
  input  logic [31:0]       rvfi_insn,
  input  logic              rvfi_trap,
  input  logic [31:0]       rvfi_pc_rdata,
  input  logic [31:0]       rvfi_pc_wdata,
  input  logic [31:0]       rvfi_mem_addr,
  input  logic [3:0]        rvfi_mem_rmask,
  input  logic [3:0]        rvfi_mem_wmask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_order,
  output logic [31:0]       out_insn,
  output logic              out_trap,
  output logic [31:0]       out_pc_rdata,
  output logic [31:0]       out_pc_wdata,
  output logic [31:0]       out_mem_addr,
  output logic [3:0]        out_mem_rmask,
  output logic [3:0]        out_mem_wmask,
  output logic [LW-1:0]     level,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count,
  output logic              order_err
);

  localparam int PW = $clog2(DEPTH);

  // Record storage. It has no reset; only the control state is reset.
  logic [63:0] orderMem [DEPTH];
  logic [31:0] insnMem  [DEPTH];
  logic        trapMem  [DEPTH];
  logic [31:0] pcRMem   [DEPTH];
  logic [31:0] pcWMem   [DEPTH];
`ifdef RVFI_BUF_MEM_EN
  logic [31:0] addrMem  [DEPTH];
  logic [3:0]  rmaskMem [DEPTH];
  logic [3:0]  wmaskMem [DEPTH];
`endif

  logic [PW-1:0]     wrPtr_q, wrPtr_d;
  logic [PW-1:0]     rdPtr_q, rdPtr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              orderErr_q, orderErr_d;
  logic              expValid_q, expValid_d;
  logic [63:0]       expOrder_q, expOrder_d;

  logic push, pop, full, accept, drop;

  // Decode the handshake. Clear discards both the incoming record and any pop.
  // When the FIFO is full, a concurrent pop frees the slot being written.
  always_comb begin
    full   = (level_q == LW'(DEPTH));
    push   = rvfi_valid && !clear;
    pop    = (level_q != '0) && out_ready && !clear;
    accept = push && (!full || pop);
    drop   = push && full && !pop;
  end

  // Next-state logic for the pointers, occupancy, loss flags and order tracker.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    orderErr_d = orderErr_q;
    expValid_d = expValid_q;
    expOrder_d = expOrder_q;
    if (clear) begin
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      level_d    = '0;
      overflow_d = 1'b0;
      drop_d     = '0;
      orderErr_d = 1'b0;
      expValid_d = 1'b0;
    end else begin
      if (accept) wrPtr_d = wrPtr_q + PW'(1);
      if (pop)    rdPtr_d = rdPtr_q + PW'(1);
      if (accept && !pop)      level_d = level_q + LW'(1);
      else if (pop && !accept) level_d = level_q - LW'(1);
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
      end
      if (push) begin
        if (expValid_q && (rvfi_order != expOrder_q)) orderErr_d = 1'b1;
        expOrder_d = rvfi_order + 64'd1;
        expValid_d = 1'b1;
      end
    end
  end

  // Control state registers. An asynchronous reset loses all buffered records at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      orderErr_q <= 1'b0;
      expValid_q <= 1'b0;
      expOrder_q <= '0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      orderErr_q <= orderErr_d;
      expValid_q <= expValid_d;
      expOrder_q <= expOrder_d;
    end
  end

  // Write each accepted record into the slot at the write pointer.
  always_ff @(posedge clock) begin
    if (accept) begin
      orderMem[wrPtr_q] <= rvfi_order;
      insnMem[wrPtr_q]  <= rvfi_insn;
      trapMem[wrPtr_q]  <= rvfi_trap;
      pcRMem[wrPtr_q]   <= rvfi_pc_rdata;
      pcWMem[wrPtr_q]   <= rvfi_pc_wdata;
`ifdef RVFI_BUF_MEM_EN
      addrMem[wrPtr_q]  <= rvfi_mem_addr;
      rmaskMem[wrPtr_q] <= rvfi_mem_rmask;
      wmaskMem[wrPtr_q] <= rvfi_mem_wmask;
`endif
    end
  end

  // Drive the head record, gated to zero while empty so stale storage never leaks out.
  always_comb begin
    out_valid     = (level_q != '0);
    out_order     = out_valid ? orderMem[rdPtr_q] : '0;
    out_insn      = out_valid ? insnMem[rdPtr_q]  : '0;
    out_trap      = out_valid ? trapMem[rdPtr_q]  : 1'b0;
    out_pc_rdata  = out_valid ? pcRMem[rdPtr_q]   : '0;
    out_pc_wdata  = out_valid ? pcWMem[rdPtr_q]   : '0;
`ifdef RVFI_BUF_MEM_EN
    out_mem_addr  = out_valid ? addrMem[rdPtr_q]  : '0;
    out_mem_rmask = out_valid ? rmaskMem[rdPtr_q] : '0;
    out_mem_wmask = out_valid ? wmaskMem[rdPtr_q] : '0;
`else
    out_mem_addr  = '0;
    out_mem_rmask = '0;
    out_mem_wmask = '0;
`endif
  end

`ifndef RVFI_BUF_MEM_EN
  logic unusedMem;
  assign unusedMem = ^{rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask};
`endif

  assign level      = level_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;
  assign order_err  = orderErr_q;

endmodule

// File: tb/tb_rvfi_retire_buffer.sv
// tb_rvfi_retire_buffer: scoreboard bench for rvfi_retire_buffer.
// Expected records are queued when pushed and compared when popped.
module tb_rvfi_retire_buffer;

  localparam int DEPTH  = 8;
  localparam int DROP_W = 16;
  localparam int LW     = $clog2(DEPTH + 1);
`ifdef RVFI_BUF_MEM_EN
  localparam bit MEM_EN = 1'b1;
`else
  localparam bit MEM_EN = 1'b0;
`endif

  typedef struct {
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic [31:0] pcR;
    logic [31:0] pcW;
    logic [31:0] memAddr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
  } rec_t;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              clear = 1'b0;
  logic              rvfi_valid = 1'b0;
  logic [63:0]       rvfi_order = '0;
  logic [31:0]       rvfi_insn = '0;
  logic              rvfi_trap = 1'b0;
  logic [31:0]       rvfi_pc_rdata = '0;
  logic [31:0]       rvfi_pc_wdata = '0;
  logic [31:0]       rvfi_mem_addr = '0;
  logic [3:0]        rvfi_mem_rmask = '0;
  logic [3:0]        rvfi_mem_wmask = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [63:0]       out_order;
  logic [31:0]       out_insn;
  logic              out_trap;
  logic [31:0]       out_pc_rdata;
  logic [31:0]       out_pc_wdata;
  logic [31:0]       out_mem_addr;
  logic [3:0]        out_mem_rmask;
  logic [3:0]        out_mem_wmask;
  logic [LW-1:0]     level;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;
  logic              order_err;

  rvfi_retire_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_trap(rvfi_trap), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
    .rvfi_mem_wmask(rvfi_mem_wmask),
    .out_valid(out_valid), .out_ready(out_ready), .out_order(out_order),
    .out_insn(out_insn), .out_trap(out_trap), .out_pc_rdata(out_pc_rdata),
    .out_pc_wdata(out_pc_wdata), .out_mem_addr(out_mem_addr),
    .out_mem_rmask(out_mem_rmask), .out_mem_wmask(out_mem_wmask),
    .level(level), .overflow(overflow), .drop_count(drop_count), .order_err(order_err)
  );

  // Free-running clock with rising edges at 5, 15, 25, ...
  always #5 clock = ~clock;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state.
  rec_t        sbQ[$];
  logic        mOverflow = 1'b0;
  int          mDrops = 0;
  logic        mOrderErr = 1'b0;
  logic        mExpValid = 1'b0;
  logic [63:0] mExpOrder = '0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic rec_t mkRec(input logic [63:0] ord);
    rec_t r;
    r.order   = ord;
    r.insn    = 32'h00000013 + {ord[15:0], 16'h0000};
    r.trap    = ord[0];
    r.pcR     = 32'h80000000 + {ord[29:0], 2'b00};
    r.pcW     = r.pcR + 32'd4;
    r.memAddr = 32'h00001000 + ord[31:0];
    r.rmask   = ord[3:0];
    r.wmask   = ~ord[3:0];
    return r;
  endfunction

  // Compare the flags, occupancy and empty-gating against the model.
  task automatic checkState();
    checkOutput("level", 64'(level), 64'(sbQ.size()));
    checkOutput("outValid", 64'(out_valid), 64'(sbQ.size() > 0));
    checkOutput("overflow", 64'(overflow), 64'(mOverflow));
    checkOutput("dropCount", 64'(drop_count), 64'(mDrops));
    checkOutput("orderErr", 64'(order_err), 64'(mOrderErr));
    if (sbQ.size() == 0) begin
      checkOutput("gatedOrder", out_order, 64'd0);
      checkOutput("gatedInsn", 64'(out_insn), 64'd0);
      checkOutput("gatedPc", 64'(out_pc_rdata), 64'd0);
    end
  endtask

  // Drive one cycle of stimulus, update the model, then check after the edge.
  task automatic applyStimulus(input logic v, input rec_t r, input logic rdy, input logic clr);
    logic mPop;
    logic mFull;
    rec_t head;
    rvfi_valid     = v;
    rvfi_order     = r.order;
    rvfi_insn      = r.insn;
    rvfi_trap      = r.trap;
    rvfi_pc_rdata  = r.pcR;
    rvfi_pc_wdata  = r.pcW;
    rvfi_mem_addr  = r.memAddr;
    rvfi_mem_rmask = r.rmask;
    rvfi_mem_wmask = r.wmask;
    out_ready      = rdy;
    clear          = clr;
    mFull = (sbQ.size() == DEPTH);
    mPop  = !clr && rdy && (sbQ.size() > 0);
    if (mPop) begin
      head = sbQ.pop_front();
      checkOutput("popOrder", out_order, head.order);
      checkOutput("popInsn", 64'(out_insn), 64'(head.insn));
      checkOutput("popTrap", 64'(out_trap), 64'(head.trap));
      checkOutput("popPcR", 64'(out_pc_rdata), 64'(head.pcR));
      checkOutput("popPcW", 64'(out_pc_wdata), 64'(head.pcW));
      checkOutput("popMemAddr", 64'(out_mem_addr), MEM_EN ? 64'(head.memAddr) : 64'd0);
      checkOutput("popRmask", 64'(out_mem_rmask), MEM_EN ? 64'(head.rmask) : 64'd0);
      checkOutput("popWmask", 64'(out_mem_wmask), MEM_EN ? 64'(head.wmask) : 64'd0);
    end
    if (clr) begin
      sbQ.delete();
      mOverflow = 1'b0;
      mDrops    = 0;
      mOrderErr = 1'b0;
      mExpValid = 1'b0;
    end else if (v) begin
      if (mExpValid && (r.order != mExpOrder)) mOrderErr = 1'b1;
      mExpOrder = r.order + 64'd1;
      mExpValid = 1'b1;
      if (mFull && !mPop) begin
        mOverflow = 1'b1;
        if (mDrops != (1 << DROP_W) - 1) mDrops++;
      end else begin
        sbQ.push_back(r);
      end
    end
    @(posedge clock);
    #1;
    rvfi_valid = 1'b0;
    out_ready  = 1'b0;
    clear      = 1'b0;
    checkState();
  endtask

  task automatic pushRec(input logic [63:0] ord);
    applyStimulus(1'b1, mkRec(ord), 1'b0, 1'b0);
  endtask

  task automatic popOne();
    applyStimulus(1'b0, mkRec(64'd0), 1'b1, 1'b0);
  endtask

  task automatic drainAll();
    for (int i = 0; i < DEPTH + 2 && sbQ.size() > 0; i++) popOne();
    checkOutput("drained", 64'(level), 64'd0);
  endtask

  task automatic doClear();
    applyStimulus(1'b0, mkRec(64'd0), 1'b0, 1'b1);
  endtask

  initial begin
    rec_t r;
    logic [63:0] nextOrder;
    logic v;
    logic rdy;
    #12;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    checkState();

    // Single record including mem fields.
    r.order = 64'd5; r.insn = 32'h00000013; r.trap = 1'b0;
    r.pcR = 32'h80000000; r.pcW = 32'h80000004;
    r.memAddr = 32'h00001000; r.rmask = 4'hF; r.wmask = 4'h0;
    applyStimulus(1'b1, r, 1'b0, 1'b0);
    checkOutput("singleInsn", 64'(out_insn), 64'h13);
    checkOutput("singlePcW", 64'(out_pc_wdata), 64'h80000004);
    checkOutput("macroAddr", 64'(out_mem_addr), MEM_EN ? 64'h1000 : 64'd0);
    checkOutput("macroRmask", 64'(out_mem_rmask), MEM_EN ? 64'hF : 64'd0);
    popOne();
    doClear();

    // Fill past capacity with the consumer stalled.
    for (int i = 0; i < 10; i++) pushRec(64'(i));
    checkOutput("fillLevel", 64'(level), 64'd8);
    checkOutput("fillOverflow", 64'(overflow), 64'd1);
    checkOutput("fillDrops", 64'(drop_count), 64'd2);
    checkOutput("fillOrderErr", 64'(order_err), 64'd0);
    drainAll();
    doClear();

    // Full FIFO accepting a push while popping.
    for (int i = 0; i < 8; i++) pushRec(64'(i));
    applyStimulus(1'b1, mkRec(64'd8), 1'b1, 1'b0);
    checkOutput("fullPpLevel", 64'(level), 64'd8);
    checkOutput("fullPpDrops", 64'(drop_count), 64'd0);
    for (int i = 0; i < 7; i++) popOne();
    checkOutput("lastHead", out_order, 64'd8);
    drainAll();
    doClear();

    // Order gap.
    pushRec(64'd3);
    pushRec(64'd4);
    pushRec(64'd6);
    checkOutput("gapErr", 64'(order_err), 64'd1);
    checkOutput("gapLevel", 64'(level), 64'd3);
    drainAll();

    // Clear mid-stream with a concurrent push.
    doClear();
    pushRec(64'd20);
    pushRec(64'd21);
    pushRec(64'd22);
    pushRec(64'd30);
    applyStimulus(1'b1, mkRec(64'd31), 1'b0, 1'b1);
    checkOutput("clrLevel", 64'(level), 64'd0);
    checkOutput("clrOrderErr", 64'(order_err), 64'd0);
    pushRec(64'd100);
    checkOutput("postClrErr", 64'(order_err), 64'd0);
    drainAll();

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 4; i++) pushRec(64'(200 + i));
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rstValid", 64'(out_valid), 64'd0);
    checkOutput("rstLevel", 64'(level), 64'd0);
    checkOutput("rstOrder", out_order, 64'd0);
    checkOutput("rstInsn", 64'(out_insn), 64'd0);
    sbQ.delete();
    mOverflow = 1'b0; mDrops = 0; mOrderErr = 1'b0; mExpValid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    checkState();

    // Random traffic with sequential orders.
    nextOrder = 64'd500;
    for (int i = 0; i < 60; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      applyStimulus(v, mkRec(nextOrder), rdy, 1'b0);
      if (v) nextOrder = nextOrder + 64'd1;
    end
    drainAll();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
